// File: rtl/rr_arb_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The master side issues req/done; the slave side (the arbiter) returns the grant.
interface rr_arb_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, done, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter with grant hold, done release and hold timeout.
// Grant, index, valid and timeout are all registered; one idle cycle separates grants.
module rr_arb_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  rr_arb_4_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       gnt, gnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             gv, gv_nxt;
  logic             tmo, tmo_nxt;
  logic [2:0]       pick;
  logic             hold_hit;

  // Returns {found, index} of the first set request searching ptr, ptr+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] cand;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 0; i < 4; i++) begin
      cand = p + 2'(i);
      if (!res[2] && r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // Counter saturates rather than wrapping so a disabled timeout never misfires.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign pick     = rr_pick(bus.req, ptr);
  assign hold_hit = (MAX_HOLD != 0) && (cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    idx_nxt   = idx;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          gnt_nxt   = 4'b0001 << pick[1:0];
          idx_nxt   = pick[1:0];
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (bus.done || !bus.req[idx] || hold_hit) begin
          // done outranks the timeout, so the pulse only fires on a pure hold expiry
          tmo_nxt   = !bus.done && bus.req[idx] && hold_hit;
          gnt_nxt   = 4'b0000;
          idx_nxt   = 2'd0;
          ptr_nxt   = idx + 2'd1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: state_nxt = IDLE;
    endcase
    gv_nxt = |gnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      gnt   <= 4'b0000;
      idx   <= 2'd0;
      gv    <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      idx   <= idx_nxt;
      gv    <= gv_nxt;
      tmo   <= tmo_nxt;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.gnt_idx   = idx;
  assign bus.gnt_valid = gv;
  assign bus.timeout   = tmo;

endmodule

// File: tb/tb_rr_arb_4.sv
// Directed scoreboard bench for rr_arb_4: the driver queues the hand-computed
// post-edge outputs, and a monitor pops and checks them one cycle at a time.
module tb_rr_arb_4;

  typedef struct packed {
    logic [3:0] g;
    logic       t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  rr_arb_4_if bus ();

  rr_arb_4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req_v);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("gnt",       bus.gnt,                 e.g);
      chk("gnt_idx",   {2'b00, bus.gnt_idx},    {2'b00, enc(e.g)});
      chk("gnt_valid", {3'b000, bus.gnt_valid}, {3'b000, |e.g});
      chk("timeout",   {3'b000, bus.timeout},   {3'b000, e.t});
      chk("onehot",    {3'b000, $onehot0(bus.gnt)}, 4'b0001);
      chk("idx_enc",   {2'b00, bus.gnt_idx},    {2'b00, enc(bus.gnt)});
    end
  end

  // Drive inputs mid-cycle and queue the outputs expected after the coming edge.
  task automatic step(input logic [3:0] r, input logic d, input logic rs,
                      input logic [3:0] eg, input logic et);
    @(negedge clk);
    rst      = rs;
    bus.req  = r;
    bus.done = d;
    q.push_back('{g: eg, t: et});
  endtask

  task automatic grant_done(input logic [3:0] r, input logic [3:0] g);
    step(r, 1'b0, 1'b0, g, 1'b0);
    step(r, 1'b0, 1'b0, g, 1'b0);
    step(r, 1'b1, 1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    // Reset then idle
    step(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);
    repeat (5) step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Full rotation with done on the second grant cycle
    grant_done(4'b1111, 4'b0001);
    grant_done(4'b1111, 4'b0010);
    grant_done(4'b1111, 4'b0100);
    grant_done(4'b1111, 4'b1000);
    grant_done(4'b1111, 4'b0001);

    // ptr=1: grant 1, release -> ptr=2, then req 0011 wraps to 0
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0);
    step(4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0);
    step(4'b0011, 1'b1, 1'b0, 4'b0000, 1'b0);

    // Timeout after 8 held cycles, then re-grant via wrap from ptr=3
    repeat (8) step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1);
    step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0);
    step(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0);

    // done coinciding with the timeout edge: no timeout pulse
    repeat (8) step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0);
    step(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0);

    // Owner drops its request on the third grant cycle; ptr becomes 2
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(4'b1011, 1'b0, 1'b0, 4'b1000, 1'b0);

    // Reset during grant of 1000, then ptr=0 picks requester 0
    step(4'b1001, 1'b0, 1'b0, 4'b1000, 1'b0);
    step(4'b1001, 1'b0, 1'b1, 4'b0000, 1'b0);
    step(4'b1001, 1'b0, 1'b0, 4'b0001, 1'b0);
    step(4'b1001, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
